// File: rtl/route_request_initiator.sv
// Purpose : per-input head-flit decoder and requesting side of the switch
//           control handshake; holds a route reservation until granted,
//           streams the packet to the crossbar, then pulses routeRelieve.
// Latency : head seen in IDLE at cycle 0 -> request valid at cycle 1;
//           flits pass combinationally (data_out = data_in) once in FORWARD.
// Backpressure: ready_in follows ready_out & PortReserved in FORWARD; no flit
//           is consumed in REQUEST/RELEASE; orphan body/tail flits in IDLE
//           are always consumed and dropped.
//
// Ports:
//   clk, rst                  rising-edge clock, async active-low reset
//   data_in/valid_in/ready_in flit stream from the input buffer
//   data_out/valid_out/ready_out flit stream to the crossbar
//   routeReserveRequestValid  registered request valid to switch controller
//   routeReserveRequest       registered requested output port
//   routeRelieve              registered one-cycle release pulse
//   routeReserveStatus        one-cycle grant pulse from the controller
//   PortReserved              level: controller is holding our path
//   err_orphan                one-cycle pulse: non-head flit dropped in IDLE
//   pkt_count                 completed packets, wraps

module route_request_initiator #(
  parameter int DATA_WIDTH    = 8,
  parameter int REQUEST_WIDTH = 2,
  parameter int COUNT_WIDTH   = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [DATA_WIDTH-1:0]    data_in,
  input  logic                     valid_in,
  output logic                     ready_in,
  output logic [DATA_WIDTH-1:0]    data_out,
  output logic                     valid_out,
  input  logic                     ready_out,
  output logic                     routeReserveRequestValid,
  output logic [REQUEST_WIDTH-1:0] routeReserveRequest,
  output logic                     routeRelieve,
  input  logic                     routeReserveStatus,
  input  logic                     PortReserved,
  output logic                     err_orphan,
  output logic [COUNT_WIDTH-1:0]   pkt_count
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQUEST = 2'd1,
    FORWARD = 2'd2,
    RELEASE = 2'd3
  } state_t;

  state_t state;
  state_t stateNext;

  // Flit type lives in the two MSBs: 10 head, 00 body, 01 tail, 11 head+tail.
  // The MSB alone marks "starts a packet", the next bit alone marks
  // "ends a packet", so head+tail sets both.
  logic [1:0] flitType;
  logic       isHead;
  logic       isTail;

  assign flitType = data_in[DATA_WIDTH-1:DATA_WIDTH-2];
  assign isHead   = flitType[1];
  assign isTail   = flitType[0];

  // A flit crosses to the crossbar only while the controller holds our path.
  logic xfer;
  assign xfer = (state == FORWARD) && valid_in && ready_out && PortReserved;

  logic readyComb;
  logic validComb;

  // --------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= stateNext;
    end
  end

  // --------------------------------------------------------------------
  // Next state and combinational handshake outputs
  // --------------------------------------------------------------------
  always_comb begin
    stateNext = state;
    readyComb = 1'b0;
    validComb = 1'b0;

    case (state)
      IDLE: begin
        if (valid_in) begin
          if (isHead) begin
            // Head stays in the buffer until the path is granted.
            stateNext = REQUEST;
          end else begin
            // Orphan body/tail: swallow it so the buffer cannot wedge.
            readyComb = 1'b1;
          end
        end
      end

      REQUEST: begin
        // Grant is taken regardless of downstream readiness; backpressure
        // only matters once we are forwarding.
        if (routeReserveStatus) begin
          stateNext = FORWARD;
        end
      end

      FORWARD: begin
        validComb = valid_in && PortReserved;
        readyComb = ready_out && PortReserved;
        // A head seen mid-packet is plain payload here; only the tail bit
        // ends the packet.
        if (xfer && isTail) begin
          stateNext = RELEASE;
        end
      end

      RELEASE: begin
        stateNext = IDLE;
      end

      default: begin
        stateNext = IDLE;
      end
    endcase
  end

  // Reset must force the handshake low without waiting for a clock; in IDLE
  // readyComb would otherwise follow valid_in for a body flit.
  assign ready_in  = rst && readyComb;
  assign valid_out = rst && validComb;
  assign data_out  = data_in;

  // --------------------------------------------------------------------
  // Registered control outputs
  // --------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      routeReserveRequestValid <= 1'b0;
      routeReserveRequest      <= '0;
      routeRelieve             <= 1'b0;
      err_orphan               <= 1'b0;
      pkt_count                <= '0;
    end else begin
      // Both pulses last exactly one cycle unless re-armed below.
      routeRelieve <= 1'b0;
      err_orphan   <= 1'b0;

      case (state)
        IDLE: begin
          if (valid_in) begin
            if (isHead) begin
              routeReserveRequest      <= data_in[REQUEST_WIDTH-1:0];
              routeReserveRequestValid <= 1'b1;
            end else begin
              err_orphan <= 1'b1;
            end
          end
        end

        FORWARD: begin
          // Request valid drops on the same edge relieve rises, so the
          // controller never sees a live request alongside the release.
          if (xfer && isTail) begin
            routeReserveRequestValid <= 1'b0;
            routeRelieve             <= 1'b1;
            pkt_count                <= pkt_count + COUNT_WIDTH'(1);
          end
        end

        default: begin
          // REQUEST and RELEASE hold the registered outputs; routeRelieve
          // self-clears through the default above.
        end
      endcase
    end
  end

endmodule

// File: tb/tb_route_request_initiator.sv
module tb_route_request_initiator;

  localparam int DW = 8;
  localparam int RW = 2;
  localparam int CW = 3;  // small counter so wrap is reachable

  logic          clk;
  logic          rst;
  logic [DW-1:0] data_in;
  logic          valid_in;
  logic          ready_in;
  logic [DW-1:0] data_out;
  logic          valid_out;
  logic          ready_out;
  logic          routeReserveRequestValid;
  logic [RW-1:0] routeReserveRequest;
  logic          routeRelieve;
  logic          routeReserveStatus;
  logic          PortReserved;
  logic          err_orphan;
  logic [CW-1:0] pkt_count;

  route_request_initiator #(
    .DATA_WIDTH   (DW),
    .REQUEST_WIDTH(RW),
    .COUNT_WIDTH  (CW)
  ) dut (
    .clk                     (clk),
    .rst                     (rst),
    .data_in                 (data_in),
    .valid_in                (valid_in),
    .ready_in                (ready_in),
    .data_out                (data_out),
    .valid_out               (valid_out),
    .ready_out               (ready_out),
    .routeReserveRequestValid(routeReserveRequestValid),
    .routeReserveRequest     (routeReserveRequest),
    .routeRelieve            (routeRelieve),
    .routeReserveStatus      (routeReserveStatus),
    .PortReserved            (PortReserved),
    .err_orphan              (err_orphan),
    .pkt_count               (pkt_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic          vin;
    logic [DW-1:0] din;
    logic          rout;
    logic          st;
    logic          pr;
    logic          eRdy;
    logic          eVld;
    logic          eReqV;
    logic [RW-1:0] eReq;
    logic          eRel;
    logic          eErr;
    logic [CW-1:0] eCnt;
  } vec_t;

  vec_t          tbl[$];
  logic [DW-1:0] sb[$];   // expected crossbar flits, in order
  int            nVec;
  int            nErr;
  int            vecIdx;

  function automatic vec_t V(int vin, int din, int rout, int st, int pr,
                             int eRdy, int eVld, int eReqV, int eReq,
                             int eRel, int eErr, int eCnt);
    vec_t v;
    v.vin   = (vin != 0);
    v.din   = DW'(din);
    v.rout  = (rout != 0);
    v.st    = (st != 0);
    v.pr    = (pr != 0);
    v.eRdy  = (eRdy != 0);
    v.eVld  = (eVld != 0);
    v.eReqV = (eReqV != 0);
    v.eReq  = RW'(eReq);
    v.eRel  = (eRel != 0);
    v.eErr  = (eErr != 0);
    v.eCnt  = CW'(eCnt);
    return v;
  endfunction

  task automatic chk(input string name, input int idx, input logic [15:0] act,
                     input logic [15:0] exp);
    if (act !== exp) begin
      nErr++;
      $display("FAIL %s vec%0d: got %0h expected %0h", name, idx, act, exp);
    end
  endtask

  // One cycle: drive just after the rising edge, check at the falling edge.
  task automatic apply(input vec_t v);
    @(posedge clk);
    #1;
    valid_in           = v.vin;
    data_in            = v.din;
    ready_out          = v.rout;
    routeReserveStatus = v.st;
    PortReserved       = v.pr;
    if (v.eVld && v.rout) sb.push_back(v.din);
    @(negedge clk);
    nVec++;
    chk("ready_in",  vecIdx, 16'(ready_in),                 16'(v.eRdy));
    chk("valid_out", vecIdx, 16'(valid_out),                16'(v.eVld));
    chk("reqValid",  vecIdx, 16'(routeReserveRequestValid), 16'(v.eReqV));
    chk("request",   vecIdx, 16'(routeReserveRequest),      16'(v.eReq));
    chk("relieve",   vecIdx, 16'(routeRelieve),             16'(v.eRel));
    chk("errOrphan", vecIdx, 16'(err_orphan),               16'(v.eErr));
    chk("pktCount",  vecIdx, 16'(pkt_count),                16'(v.eCnt));
    if (valid_out && ready_out) begin
      if (sb.size() == 0) begin
        nErr++;
        $display("FAIL flit vec%0d: got unexpected flit %0h expected none", vecIdx, data_out);
      end else begin
        chk("flitData", vecIdx, 16'(data_out), 16'(sb.pop_front()));
      end
    end
    vecIdx++;
  endtask

  task automatic chkAllZero(input string tag);
    nVec++;
    chk({tag, ".ready_in"},  vecIdx, 16'(ready_in),                 16'd0);
    chk({tag, ".valid_out"}, vecIdx, 16'(valid_out),                16'd0);
    chk({tag, ".reqValid"},  vecIdx, 16'(routeReserveRequestValid), 16'd0);
    chk({tag, ".request"},   vecIdx, 16'(routeReserveRequest),      16'd0);
    chk({tag, ".relieve"},   vecIdx, 16'(routeRelieve),             16'd0);
    chk({tag, ".errOrphan"}, vecIdx, 16'(err_orphan),               16'd0);
    chk({tag, ".pktCount"},  vecIdx, 16'(pkt_count),                16'd0);
    vecIdx++;
  endtask

  initial begin
    nVec   = 0;
    nErr   = 0;
    vecIdx = 0;

    // ---- single packet 82/15/4A, grant at cycle 3 ----
    tbl.push_back(V(1,'h82,1,0,0, 0,0,0,0,0,0,0));
    tbl.push_back(V(1,'h82,1,0,0, 0,0,1,2,0,0,0));
    tbl.push_back(V(1,'h82,1,0,0, 0,0,1,2,0,0,0));
    tbl.push_back(V(1,'h82,1,1,0, 0,0,1,2,0,0,0));
    tbl.push_back(V(1,'h82,1,0,1, 1,1,1,2,0,0,0));
    tbl.push_back(V(1,'h15,1,0,1, 1,1,1,2,0,0,0));
    tbl.push_back(V(1,'h4A,1,0,1, 1,1,1,2,0,0,0));
    tbl.push_back(V(0,'h00,1,0,0, 0,0,0,2,1,0,1));
    tbl.push_back(V(0,'h00,1,0,0, 0,0,0,2,0,0,1));
    // ---- contention: grant at cycle 12 with ready_out low ----
    tbl.push_back(V(1,'h82,0,0,0, 0,0,0,2,0,0,1));
    for (int i = 1; i <= 11; i++) tbl.push_back(V(1,'h82,0,0,0, 0,0,1,2,0,0,1));
    tbl.push_back(V(1,'h82,0,1,0, 0,0,1,2,0,0,1));
    tbl.push_back(V(1,'h82,1,0,1, 1,1,1,2,0,0,1));
    tbl.push_back(V(1,'h7F,1,0,1, 1,1,1,2,0,0,1));
    tbl.push_back(V(0,'h00,1,1,1, 0,0,0,2,1,0,2));  // status in RELEASE ignored
    tbl.push_back(V(0,'h00,1,1,0, 0,0,0,2,0,0,2));  // status in IDLE ignored
    tbl.push_back(V(0,'h00,1,0,0, 0,0,0,2,0,0,2));
    // ---- backpressure, mid-packet head, PortReserved low, back-to-back ----
    tbl.push_back(V(1,'h80,1,0,0, 0,0,0,2,0,0,2));
    tbl.push_back(V(1,'h80,1,0,0, 0,0,1,0,0,0,2));
    tbl.push_back(V(1,'h80,1,1,0, 0,0,1,0,0,0,2));
    tbl.push_back(V(1,'h80,1,0,1, 1,1,1,0,0,0,2));
    for (int i = 0; i < 3; i++) tbl.push_back(V(1,'h15,0,0,1, 0,1,1,0,0,0,2));
    tbl.push_back(V(1,'h15,1,0,1, 1,1,1,0,0,0,2));
    tbl.push_back(V(1,'h93,1,0,1, 1,1,1,0,0,0,2));
    tbl.push_back(V(1,'h4A,1,0,0, 0,0,1,0,0,0,2));
    tbl.push_back(V(1,'h4A,1,0,1, 1,1,1,0,0,0,2));
    tbl.push_back(V(1,'hC1,1,0,0, 0,0,0,0,1,0,3));
    tbl.push_back(V(1,'hC1,1,0,0, 0,0,0,0,0,0,3));
    tbl.push_back(V(1,'hC1,1,1,0, 0,0,1,1,0,0,3));
    tbl.push_back(V(1,'hC1,1,0,1, 1,1,1,1,0,0,3));
    tbl.push_back(V(0,'h00,1,0,0, 0,0,0,1,1,0,4));
    tbl.push_back(V(0,'h00,1,0,0, 0,0,0,1,0,0,4));
    // ---- orphan body then orphan tail in IDLE ----
    tbl.push_back(V(1,'h05,1,0,0, 1,0,0,1,0,0,4));
    tbl.push_back(V(1,'h4A,1,0,0, 1,0,0,1,0,1,4));
    tbl.push_back(V(0,'h00,1,0,0, 0,0,0,1,0,1,4));
    tbl.push_back(V(0,'h00,1,0,0, 0,0,0,1,0,0,4));

    // ---- reset state, checked before any clock edge ----
    rst                = 1'b0;
    valid_in           = 1'b1;
    data_in            = 8'h05;
    ready_out          = 1'b1;
    routeReserveStatus = 1'b0;
    PortReserved       = 1'b0;
    #3;
    chkAllZero("reset");
    #9;  // t=12, between edges
    valid_in = 1'b0;
    rst      = 1'b1;

    for (int i = 0; i < tbl.size(); i++) apply(tbl[i]);

    // ---- reset mid-packet in FORWARD ----
    apply(V(1,'h81,1,0,0, 0,0,0,1,0,0,4));
    apply(V(1,'h81,1,1,0, 0,0,1,1,0,0,4));
    apply(V(1,'h81,1,0,1, 1,1,1,1,0,0,4));
    @(posedge clk);
    #1;
    data_in = 8'h15;
    #2;
    rst = 1'b0;
    #1;
    chkAllZero("midReset");
    @(negedge clk);
    @(negedge clk);
    #1;
    valid_in     = 1'b0;
    PortReserved = 1'b0;
    rst          = 1'b1;
    apply(V(1,'h83,1,0,0, 0,0,0,0,0,0,0));
    apply(V(1,'h83,1,0,0, 0,0,1,3,0,0,0));
    apply(V(1,'h83,1,1,0, 0,0,1,3,0,0,0));
    apply(V(1,'h83,1,0,1, 1,1,1,3,0,0,0));
    apply(V(1,'h7F,1,0,1, 1,1,1,3,0,0,0));
    apply(V(0,'h00,1,0,0, 0,0,0,3,1,0,1));
    apply(V(0,'h00,1,0,0, 0,0,0,3,0,0,1));

    // ---- single-flit packets until pkt_count wraps ----
    for (int k = 1; k <= 8; k++) begin
      apply(V(1,'hC2,1,0,0, 0,0,0,(k == 1) ? 3 : 2,0,0,k));
      apply(V(1,'hC2,1,1,0, 0,0,1,2,0,0,k));
      apply(V(1,'hC2,1,0,1, 1,1,1,2,0,0,k));
      apply(V(0,'h00,1,0,0, 0,0,0,2,1,0,(k + 1) % 8));
    end

    nVec++;
    chk("scoreboardEmpty", vecIdx, 16'(sb.size()), 16'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
    $finish;
  end

endmodule
